// File: rtl/led_framebuffer.sv
// Double-buffered frame store feeding the HUB75 scanner: a raster pixel stream fills
// the back page while the scanner reads upper/lower halves of the front page.
module led_framebuffer #(
   parameter int XBITS = 7,
   parameter int YBITS = 5,
   parameter int CBITS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [XBITS-1:0]   addrx,
   input  logic [YBITS-1:0]   addry,
   input  logic               frame_end,
   output logic [CBITS-1:0]   r0,
   output logic [CBITS-1:0]   g0,
   output logic [CBITS-1:0]   b0,
   output logic [CBITS-1:0]   r1,
   output logic [CBITS-1:0]   g1,
   output logic [CBITS-1:0]   b1,
   input  logic [3*CBITS-1:0] wr_data,
   input  logic               wr_sof,
   input  logic               wr_valid,
   output logic               wr_ready,
   output logic               front_page,
   output logic               swapped
);
   localparam int DW    = 3 * CBITS;
   localparam int PW    = XBITS + YBITS + 1;   // write pointer: {bank, y, x}
   localparam int AW    = XBITS + YBITS + 1;   // bank address: {page, y, x}
   localparam int DEPTH = 1 << AW;
   localparam logic [PW-1:0] PTR_MAX = '1;

   typedef enum logic {FILL = 1'b0, WAIT_SWAP = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          front_q, front_d;
   logic          swapped_q, swapped_d;
   logic          ready_q, ready_d;

   logic [PW-1:0] wr_ptr;
   logic          wr_fire;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;

   logic [DW-1:0] mem_u [DEPTH];
   logic [DW-1:0] mem_l [DEPTH];
   logic [DW-1:0] rd_u_q, rd_l_q;

   // wr_valid/wr_ready: a pixel moves on every clock where both are high; the
   // writer holds wr_data/wr_sof stable until that happens.
   assign wr_fire = wr_valid & ready_q;
   assign wr_ptr  = wr_sof ? '0 : ptr_q;
   assign wr_addr = {~front_q, wr_ptr[PW-2:0]};
   assign rd_addr = {front_q, addry, addrx};

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      front_d   = front_q;
      swapped_d = 1'b0;
      ready_d   = ready_q;
      case (state_q)
         FILL: begin
            ready_d = 1'b1;
            if (wr_fire) begin
               ptr_d = wr_ptr + PW'(1);
               if (wr_ptr == PTR_MAX) begin
                  state_d = WAIT_SWAP;
                  ready_d = 1'b0;
                  ptr_d   = '0;
               end
            end
         end
         WAIT_SWAP: begin
            ready_d = 1'b0;
            // Swap only on a scanner frame boundary so the panel never tears.
            if (frame_end) begin
               front_d   = ~front_q;
               swapped_d = 1'b1;
               ptr_d     = '0;
               state_d   = FILL;
               ready_d   = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FILL;
         ptr_q     <= '0;
         front_q   <= 1'b0;
         swapped_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         front_q   <= front_d;
         swapped_q <= swapped_d;
         ready_q   <= ready_d;
      end
   end

   // Memory itself is not reset; it only becomes visible after the first swap.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         if (wr_ptr[PW-1]) mem_l[wr_addr] <= wr_data;
         else              mem_u[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_u_q <= '0;
         rd_l_q <= '0;
      end else begin
         rd_u_q <= mem_u[rd_addr];
         rd_l_q <= mem_l[rd_addr];
      end
   end

   assign r0 = rd_u_q[CBITS-1:0];
   assign g0 = rd_u_q[2*CBITS-1:CBITS];
   assign b0 = rd_u_q[3*CBITS-1:2*CBITS];
   assign r1 = rd_l_q[CBITS-1:0];
   assign g1 = rd_l_q[2*CBITS-1:CBITS];
   assign b1 = rd_l_q[3*CBITS-1:2*CBITS];

   assign wr_ready   = ready_q;
   assign front_page = front_q;
   assign swapped    = swapped_q;

endmodule

// File: tb/tb_led_framebuffer.sv
// Bench for led_framebuffer: random-address reads every cycle are checked against a
// frame-level model holding both pages as plain raster arrays.
module tb_led_framebuffer;
   localparam int XB = 5;
   localparam int YB = 4;
   localparam int CB = 8;
   localparam int DW = 3 * CB;
   localparam int W  = 1 << XB;
   localparam int H  = 1 << YB;
   localparam int N  = W * 2 * H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [XB-1:0] addrx = '0;
   logic [YB-1:0] addry = '0;
   logic          frame_end = 1'b0;
   logic [CB-1:0] r0, g0, b0, r1, g1, b1;
   logic [DW-1:0] wr_data = '0;
   logic          wr_sof = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready, front_page, swapped;

   led_framebuffer #(.XBITS(XB), .YBITS(YB), .CBITS(CB)) dut (
      .clk(clk), .rst_n(rst_n), .addrx(addrx), .addry(addry), .frame_end(frame_end),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .wr_data(wr_data), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .front_page(front_page), .swapped(swapped)
   );

   always #5 clk = ~clk;

   // Reference model: two pages indexed by raster position y*W+x, y spanning both halves.
   logic [DW-1:0] ref_mem [2][N];
   bit            ref_ok  [2][N];
   bit            exp_ready, exp_front, exp_swapped, exp_rd_ok, full;
   logic [DW-1:0] exp_up, exp_lo;
   int            wpos;
   logic          next_rst = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int i);
      int x, y;
      x = i % W;
      y = i / W;
      return {8'(y), 8'(x), 8'(x ^ y)};
   endfunction

   // One clock: drive inputs at the falling edge, check outputs, advance the model.
   task automatic step(input logic v, input logic s, input logic fe,
                       input logic [DW-1:0] d, input int ax, input int ay);
      int pos, iu, il, f;
      @(negedge clk);
      rst_n = next_rst;
      wr_valid = v; wr_sof = s; frame_end = fe; wr_data = d;
      addrx = XB'(ax); addry = YB'(ay);
      chk_eq("wr_ready", 32'(wr_ready), 32'(exp_ready));
      chk_eq("front_page", 32'(front_page), 32'(exp_front));
      chk_eq("swapped", 32'(swapped), 32'(exp_swapped));
      if (exp_rd_ok) begin
         chk_eq("upper_pixel", 32'({b0, g0, r0}), 32'(exp_up));
         chk_eq("lower_pixel", 32'({b1, g1, r1}), 32'(exp_lo));
      end
      f  = int'(exp_front);
      iu = ay * W + ax;
      il = (ay + H) * W + ax;
      if (!rst_n) begin
         exp_ready = 0; exp_front = 0; exp_swapped = 0; full = 0; wpos = 0;
         exp_up = '0; exp_lo = '0; exp_rd_ok = 1;
      end else begin
         exp_rd_ok = ref_ok[f][iu] && ref_ok[f][il];
         exp_up = ref_mem[f][iu];
         exp_lo = ref_mem[f][il];
         exp_swapped = 0;
         if (full) begin
            if (fe) begin
               exp_front = !exp_front; exp_swapped = 1; full = 0; wpos = 0;
            end
         end else if (v && exp_ready) begin
            pos = s ? 0 : wpos;
            ref_mem[1-f][pos] = d;
            ref_ok[1-f][pos] = 1;
            wpos = pos + 1;
            if (pos == N - 1) full = 1;
         end
         exp_ready = !full;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic fe);
      for (int i = 0; i < n; i++) step(0, 0, fe, '0, $urandom_range(0, W-1), $urandom_range(0, H-1));
   endtask

   // Offers one pixel (held, like the real writer) until the model says it was taken.
   task automatic send(input logic s, input logic [DW-1:0] d);
      bit r = 0;
      for (int t = 0; t < 64 && !r; t++) begin
         r = exp_ready;
         step(1, s, 0, d, $urandom_range(0, W-1), $urandom_range(0, H-1));
      end
      chk_eq("send_accepted", 32'(r), 32'd1);
   endtask

   task automatic sweep();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) step(0, 0, 0, '0, x, y);
      idle(1, 0);
   endtask

   initial begin
      logic [DW-1:0] sofpix;
      repeat (2) @(posedge clk);
      exp_ready = 0; exp_front = 0; exp_swapped = 0; full = 0; wpos = 0;
      exp_up = '0; exp_lo = '0; exp_rd_ok = 1;

      // Reset held, then released.
      idle(3, 0);
      next_rst = 1'b1;
      idle(3, 0);

      // Full frame of the coordinate pattern, then a swap and a full sweep.
      for (int i = 0; i < N; i++) send(i == 0, pix(i));
      idle(3, 0);
      idle(1, 1);
      idle(2, 0);
      sweep();

      // Abandoned partial frame followed by a complete frame.
      for (int i = 0; i < 300; i++) send(i == 0, DW'($urandom));
      for (int i = 0; i < N; i++) send(i == 0, pix(i) ^ 24'h5a3c96);
      idle(1, 1);
      idle(1, 0);
      sweep();

      // Last pixel coincides with frame_end: no swap; writer holds sof meanwhile.
      for (int i = 0; i < N - 1; i++) send(i == 0, DW'($urandom));
      step(1, 0, 1, DW'($urandom), 0, 0);
      sofpix = DW'($urandom);
      for (int i = 0; i < 5; i++) step(1, 1, 0, sofpix, $urandom_range(0, W-1), $urandom_range(0, H-1));
      step(1, 1, 1, sofpix, 0, 0);
      send(1, sofpix);
      idle(2, 0);

      // Random writer gaps with frame_end pulses that must be ignored in FILL.
      send(1, DW'($urandom));
      for (int c = 0; c < 6 * N && !full; c++)
         step(1'($urandom_range(0, 1)), 0, ($urandom_range(0, 7) == 0), DW'($urandom),
              $urandom_range(0, W-1), $urandom_range(0, H-1));
      chk_eq("random_fill_done", 32'(full), 32'd1);
      idle(3, 0);
      idle(1, 1);
      idle(3, 0);

      // Reset while waiting for the swap.
      for (int i = 0; i < N; i++) send(i == 0, DW'($urandom));
      idle(2, 0);
      next_rst = 1'b0;
      idle(3, 0);
      next_rst = 1'b1;
      idle(2, 0);
      for (int i = 0; i < 8; i++) send(i == 0, DW'($urandom));
      idle(2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
